hamming_encoder: RTL and testbench
==================================

Name: hamming_encoder

Overview:
- Pipelined Hamming (single-error-correcting) parity generator for a parallel data word.
- Sits in front of the serializer: the serializer shifts out the data word, then shifts out the parity bits captured from this block.
- Registered outputs, one-cycle latency, valid-qualified.

Parameters:
- DATA_WIDTH, 8, width of the input data word; legal range ≥ 2.
- CODE_BITS, derived localparam (not overridable): smallest r with 2^r ≥ DATA_WIDTH + r + 1. Values: 8→4, 4→3, 16→5, 11→4, 26→5.
- CODED_WIDTH, derived localparam: DATA_WIDTH + CODE_BITS. For DATA_WIDTH=8 this is 12.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_n_i  input  1  reset, asynchronous assert, active-low.
- data_in_i  input  DATA_WIDTH  data word to encode.
- valid_in_i  input  1  data_in_i is valid this cycle.
- data_out_o  output  DATA_WIDTH  registered copy of the captured data word.
- parity_bits_o  output  CODE_BITS  registered Hamming parity bits of the captured word.
- valid_out_o  output  1  one-cycle pulse: data_out_o and parity_bits_o are newly updated.

Behaviour:
- Reset: while rst_n_i=0, asynchronously force data_out_o=0, parity_bits_o=0, valid_out_o=0. Reset is released synchronously by the clock.
- Reset asserted mid-operation discards any pending word; no valid_out_o is produced for it.
- Codeword layout:
  - Positions are numbered 1..CODED_WIDTH.
  - Power-of-two positions (1, 2, 4, 8, …) hold parity bits.
  - Data bits fill the remaining positions in ascending order: data_in_i[0] at position 3, [1] at 5, [2] at 6, [3] at 7, [4] at 9, and so on.
- Parity rule: parity_bits_o[k] is the even-parity XOR of every data bit whose position index has bit k set (k = 0..CODE_BITS-1).
- Capture: on a rising edge with valid_in_i=1, register data_in_i into data_out_o and its parity into parity_bits_o, and set valid_out_o=1.
- Latency: outputs appear exactly 1 cycle after the valid_in_i cycle.
- valid_in_i=0: valid_out_o=0. data_out_o and parity_bits_o hold their last values; they are not cleared.
- Back-to-back valid_in_i: one result per cycle, full throughput, no stall, no ready signal. valid_out_o stays high for the matching number of cycles.
- No backpressure: the consumer must sample the outputs in the valid_out_o cycle or rely on the hold behaviour.
- Parity generation is purely combinational XOR ahead of the output register. No multi-cycle paths.
- The parity function must be generic in DATA_WIDTH (loop over positions), with no hardcoded width-8 tables.

Decomposition:
- gray_area_package holds a constant function calc_code_bits(data_width) that returns CODE_BITS. The shared hamming defines use it for CODE_BITS and CODED_WIDTH, so the serializer and any decoder agree on widths.
- gray_area_package also holds a constant function that maps data index to codeword position, shared with the future decoder.
- No sub-module: a single module containing a combinational parity function plus the output register stage.

Test Plan:
- Reset: hold rst_n_i=0 with random data_in_i and valid_in_i=1; deassert reset asynchronously mid-cycle -> all outputs 0 while in reset, no valid_out_o pulse.
- DATA_WIDTH=8, single words with valid for 1 cycle. Each -> next cycle valid_out_o=1 and the listed data_out_o / parity_bits_o:
  - 0x00 -> data 0x00, parity 4'b0000
  - 0x01 -> data 0x01, parity 4'b0011
  - 0x0F -> data 0x0F, parity 4'b0111
  - 0xF0 -> data 0xF0, parity 4'b0100
  - 0x80 -> data 0x80, parity 4'b1100
  - 0xFF -> data 0xFF, parity 4'b0011
- Back-to-back: valid high for 3 cycles with 0x0F, 0xF0, 0xFF -> valid_out_o high for 3 cycles with parity 0111, 0100, 0011 on consecutive cycles.
- Hold: send 0x80, then valid low for 5 cycles with data_in_i toggling -> valid_out_o a single pulse; data_out_o=0x80 and parity_bits_o=1100 held throughout.
- Single-bit sweep, DATA_WIDTH=8: walking-one data -> parity equals the binary position index of that bit (3,5,6,7,9,10,11,12 → 0011, 0101, 0110, 0111, 1001, 1010, 1011, 1100).
- Random, DATA_WIDTH=4 and 16: 1000 random words with random valid -> parity matches a reference model; inserting a single-bit flip into the modelled codeword yields a syndrome equal to the flipped position.

Source files
------------

// File: rtl/hamming_encoder_pkg.sv
// rtl/hamming_encoder_pkg.sv - shared Hamming width and codeword-position helpers
package gray_area_package;

    localparam int DEFAULT_DATA_WIDTH = 8;

    // Smallest r with 2^r >= data_width + r + 1.
    function automatic int calc_code_bits(input int data_width);
        int r;
        r = 0;
        for (int i = 1; i < 32; i++) begin
            if (r == 0 && (1 << i) >= data_width + i + 1) begin
                r = i;
            end
        end
        return r;
    endfunction

    function automatic int calc_coded_width(input int data_width);
        return data_width + calc_code_bits(data_width);
    endfunction

    function automatic bit is_parity_pos(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Every power of two at or below the running position pushes the data bit one slot up.
    function automatic int data_pos(input int data_index);
        int pos;
        pos = data_index + 1;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) <= pos) begin
                pos = pos + 1;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamming_encoder.sv
// rtl/hamming_encoder.sv - single-cycle Hamming parity generator with registered outputs
module hamming_encoder
    import gray_area_package::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    localparam int CODE_BITS = calc_code_bits(DATA_WIDTH),
    localparam int CODED_WIDTH = calc_coded_width(DATA_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [DATA_WIDTH-1:0] data_in_i,
    input  logic                  valid_in_i,
    output logic [DATA_WIDTH-1:0] data_out_o,
    output logic [CODE_BITS-1:0]  parity_bits_o,
    output logic                  valid_out_o
);

    // Bits needed to write any codeword position 1..CODED_WIDTH; equals CODE_BITS by construction.
    localparam int POS_W = $clog2(CODED_WIDTH + 1);

    logic [POS_W-1:0]     pos_term [DATA_WIDTH];
    logic [CODE_BITS-1:0] parity_next;

    // XOR of set-bit positions: bit k of the result is the parity over positions with bit k set.
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_pos
        localparam int POS = data_pos(i);
        assign pos_term[i] = data_in_i[i] ? POS_W'(POS) : '0;
    end

    always_comb begin
        parity_next = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            parity_next = parity_next ^ pos_term[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_out_o    <= '0;
            parity_bits_o <= '0;
            valid_out_o   <= 1'b0;
        end else begin
            valid_out_o <= valid_in_i;
            if (valid_in_i) begin
                data_out_o    <= data_in_i;
                parity_bits_o <= parity_next;
            end
        end
    end

endmodule

// File: tb/tb_hamming_encoder.sv
// tb/tb_hamming_encoder.sv - self-checking bench for hamming_encoder at widths 8, 4 and 16
module tb_hamming_encoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [7:0]  d8 = '0;
    logic        v8 = 1'b0;
    logic [7:0]  do8;
    logic [3:0]  p8;
    logic        vo8;

    logic [3:0]  d4 = '0;
    logic        v4 = 1'b0;
    logic [3:0]  do4;
    logic [2:0]  p4;
    logic        vo4;

    logic [15:0] d16 = '0;
    logic        v16 = 1'b0;
    logic [15:0] do16;
    logic [4:0]  p16;
    logic        vo16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hamming_encoder #(.DATA_WIDTH(8)) dut8 (
        .clk_i(clk), .rst_n_i(rst_n), .data_in_i(d8), .valid_in_i(v8),
        .data_out_o(do8), .parity_bits_o(p8), .valid_out_o(vo8)
    );

    hamming_encoder #(.DATA_WIDTH(4)) dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .data_in_i(d4), .valid_in_i(v4),
        .data_out_o(do4), .parity_bits_o(p4), .valid_out_o(vo4)
    );

    hamming_encoder #(.DATA_WIDTH(16)) dut16 (
        .clk_i(clk), .rst_n_i(rst_n), .data_in_i(d16), .valid_in_i(v16),
        .data_out_o(do16), .parity_bits_o(p16), .valid_out_o(vo16)
    );

    // Reference: walk codeword positions, skip powers of two, XOR in the position of each set data bit.
    function automatic int model_parity(input logic [31:0] d, input int dw);
        int par;
        int idx;
        par = 0;
        idx = 0;
        for (int p = 1; idx < dw; p++) begin
            if ($countones(p) != 1) begin
                if (d[idx]) par = par ^ p;
                idx++;
            end
        end
        return par;
    endfunction

    // Assemble the full codeword, flip one position, return the recomputed syndrome.
    function automatic int syndrome_after_flip(input logic [31:0] d, input int par, input int dw,
                                               input int cw_len, input int flip);
        logic cw [64];
        int idx;
        int syn;
        idx = 0;
        syn = 0;
        for (int p = 0; p < 64; p++) cw[p] = 1'b0;
        for (int p = 1; p <= cw_len; p++) begin
            if ($countones(p) == 1) begin
                cw[p] = par[$clog2(p)];
            end else begin
                cw[p] = d[idx];
                idx++;
            end
        end
        if (idx != dw) syn = -1;
        cw[flip] = ~cw[flip];
        for (int p = 1; p <= cw_len; p++) begin
            if (cw[p]) syn = syn ^ p;
        end
        return syn;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        v8 = 1'b1;
        for (int n = 0; n < 4; n++) begin
            d8 = 8'($urandom);
            @(negedge clk);
            checks++;
            if (vo8 !== 1'b0 || do8 !== 8'h00 || p8 !== 4'h0) begin
                errors++;
                $display("FAIL reset_hold valid=%b data=%h parity=%b required 0/00/0000", vo8, do8, p8);
            end
        end
        v8 = 1'b0;
        #2 rst_n = 1'b1;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            checks++;
            if (vo8 !== 1'b0 || do8 !== 8'h00 || p8 !== 4'h0) begin
                errors++;
                $display("FAIL reset_release valid=%b data=%h parity=%b required 0/00/0000", vo8, do8, p8);
            end
        end
    endtask

    task automatic test_vectors();
        logic [7:0] din [6]  = '{8'h00, 8'h01, 8'h0F, 8'hF0, 8'h80, 8'hFF};
        logic [3:0] pexp [6] = '{4'b0000, 4'b0011, 4'b0111, 4'b0100, 4'b1100, 4'b0011};
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            d8 = din[n];
            v8 = 1'b1;
            @(negedge clk);
            v8 = 1'b0;
            checks++;
            if (vo8 !== 1'b1 || do8 !== din[n] || p8 !== pexp[n]) begin
                errors++;
                $display("FAIL vector_%0d valid=%b data=%h parity=%b required 1/%h/%b",
                         n, vo8, do8, p8, din[n], pexp[n]);
            end
            @(negedge clk);
            checks++;
            if (vo8 !== 1'b0) begin
                errors++;
                $display("FAIL vector_pulse_%0d valid=%b required 0", n, vo8);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] din [3]  = '{8'h0F, 8'hF0, 8'hFF};
        logic [3:0] pexp [3] = '{4'b0111, 4'b0100, 4'b0011};
        @(negedge clk);
        for (int n = 0; n < 4; n++) begin
            if (n > 0) begin
                checks++;
                if (vo8 !== 1'b1 || do8 !== din[n-1] || p8 !== pexp[n-1]) begin
                    errors++;
                    $display("FAIL b2b_%0d valid=%b data=%h parity=%b required 1/%h/%b",
                             n - 1, vo8, do8, p8, din[n-1], pexp[n-1]);
                end
            end
            if (n < 3) begin
                d8 = din[n];
                v8 = 1'b1;
            end else begin
                v8 = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (vo8 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end valid=%b required 0", vo8);
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        d8 = 8'h80;
        v8 = 1'b1;
        @(negedge clk);
        v8 = 1'b0;
        checks++;
        if (vo8 !== 1'b1 || do8 !== 8'h80 || p8 !== 4'b1100) begin
            errors++;
            $display("FAIL hold_capture valid=%b data=%h parity=%b required 1/80/1100", vo8, do8, p8);
        end
        for (int n = 0; n < 5; n++) begin
            d8 = 8'($urandom) ^ 8'hA5;
            @(negedge clk);
            checks++;
            if (vo8 !== 1'b0 || do8 !== 8'h80 || p8 !== 4'b1100) begin
                errors++;
                $display("FAIL hold_%0d valid=%b data=%h parity=%b required 0/80/1100", n, vo8, do8, p8);
            end
        end
    endtask

    task automatic test_walking_one();
        int pos [8] = '{3, 5, 6, 7, 9, 10, 11, 12};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            d8 = 8'(1 << i);
            v8 = 1'b1;
            @(negedge clk);
            v8 = 1'b0;
            checks++;
            if (vo8 !== 1'b1 || p8 !== 4'(pos[i])) begin
                errors++;
                $display("FAIL walk_bit%0d valid=%b parity=%b required 1/%b", i, vo8, p8, 4'(pos[i]));
            end
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        d8 = 8'h55;
        v8 = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (vo8 !== 1'b0 || do8 !== 8'h00 || p8 !== 4'h0) begin
            errors++;
            $display("FAIL mid_reset valid=%b data=%h parity=%b required 0/00/0000", vo8, do8, p8);
        end
        @(negedge clk);
        v8 = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (vo8 !== 1'b0 || do8 !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_release valid=%b data=%h required 0/00", vo8, do8);
        end
    endtask

    task automatic test_random_4();
        logic       e_vo = 1'b0;
        logic [3:0] e_d = '0;
        logic [2:0] e_p = '0;
        int syn;
        int flip;
        for (int n = 0; n <= 1000; n++) begin
            @(negedge clk);
            checks++;
            if (vo4 !== e_vo || do4 !== e_d || p4 !== e_p) begin
                errors++;
                $display("FAIL rand4_%0d valid=%b data=%h parity=%b required %b/%h/%b",
                         n, vo4, do4, p4, e_vo, e_d, e_p);
            end
            if (vo4 === 1'b1 && (n % 8) == 0) begin
                flip = $urandom_range(1, 7);
                syn = syndrome_after_flip({28'b0, do4}, int'(p4), 4, 7, flip);
                checks++;
                if (syn != flip) begin
                    errors++;
                    $display("FAIL syndrome4_%0d syndrome=%0d required %0d", n, syn, flip);
                end
            end
            if (n < 1000) begin
                v4 = ($urandom % 10) < 7;
                d4 = 4'($urandom);
                e_vo = v4;
                if (v4) begin
                    e_d = d4;
                    e_p = 3'(model_parity({28'b0, d4}, 4));
                end
            end else begin
                v4 = 1'b0;
            end
        end
    endtask

    task automatic test_random_16();
        logic        e_vo = 1'b0;
        logic [15:0] e_d = '0;
        logic [4:0]  e_p = '0;
        int syn;
        int flip;
        for (int n = 0; n <= 1000; n++) begin
            @(negedge clk);
            checks++;
            if (vo16 !== e_vo || do16 !== e_d || p16 !== e_p) begin
                errors++;
                $display("FAIL rand16_%0d valid=%b data=%h parity=%b required %b/%h/%b",
                         n, vo16, do16, p16, e_vo, e_d, e_p);
            end
            if (vo16 === 1'b1 && (n % 8) == 0) begin
                flip = $urandom_range(1, 21);
                syn = syndrome_after_flip({16'b0, do16}, int'(p16), 16, 21, flip);
                checks++;
                if (syn != flip) begin
                    errors++;
                    $display("FAIL syndrome16_%0d syndrome=%0d required %0d", n, syn, flip);
                end
            end
            if (n < 1000) begin
                v16 = ($urandom % 10) < 7;
                d16 = 16'($urandom);
                e_vo = v16;
                if (v16) begin
                    e_d = d16;
                    e_p = 5'(model_parity({16'b0, d16}, 16));
                end
            end else begin
                v16 = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_hold();
        test_walking_one();
        test_mid_reset();
        test_random_4();
        test_random_16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
